// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
//   Owns the PC update policy. Each cycle it produces next_inst_address and
//   pc_en for pc_reg. On an I-cache miss it freezes the PC and runs a
//   request/ack/done refill handshake. Redirects (jump/branch) and hazard
//   stalls are merged here. A redirect seen mid-miss is parked and replayed
//   once the refill has landed.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   inst_address         current PC (from pc_reg)
//   icache_hit           line holding inst_address is resident
//   stall                hazard hold request
//   jump/jump_target     jump redirect (wins over branch)
//   branch_taken/_target taken-branch redirect
//   refill_ack/_done     memory-side handshake
//   next_inst_address    D input of pc_reg
//   pc_en                pc_reg write enable (pc_reg.hit)
//   fetch_valid          instruction at inst_address is valid for IF/ID
//   refill_req/_addr     line refill request, line-aligned address
//   miss_count           saturating I-cache miss counter
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned LINE_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_address,
  input  logic        icache_hit,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        refill_ack,
  input  logic        refill_done,
  output logic [31:0] next_inst_address,
  output logic        pc_en,
  output logic        fetch_valid,
  output logic        refill_req,
  output logic [31:0] refill_addr,
  output logic [31:0] miss_count
);

  localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);

  typedef enum logic [1:0] {S_FETCH, S_MISS_REQ, S_MISS_WAIT, S_RETRY} state_e;

  state_e      state_q, state_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] refill_addr_q, refill_addr_d;
  logic [31:0] miss_count_q, miss_count_d;

  logic        redirect;
  logic [31:0] redir_tgt;

  assign redirect  = jump | branch_taken;
  assign redir_tgt = jump ? jump_target : branch_target;

  always_comb begin
    state_d           = state_q;
    pend_vld_d        = pend_vld_q;
    pend_tgt_d        = pend_tgt_q;
    refill_addr_d     = refill_addr_q;
    miss_count_d      = miss_count_q;
    pc_en             = 1'b0;
    next_inst_address = inst_address;
    fetch_valid       = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (redirect) begin
          pc_en             = 1'b1;
          next_inst_address = redir_tgt;
        end else if (stall) begin
          pc_en = 1'b0;
        end else if (icache_hit) begin
          pc_en             = 1'b1;
          next_inst_address = inst_address + 32'd4;
          fetch_valid       = 1'b1;
        end else begin
          refill_addr_d = inst_address & LINE_MASK;
          if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
          state_d = S_MISS_REQ;
        end
      end

      S_MISS_REQ, S_MISS_WAIT: begin
        // PC frozen, stall irrelevant; newest redirect wins the parking slot.
        if (redirect) begin
          pend_vld_d = 1'b1;
          pend_tgt_d = redir_tgt;
        end
        if (state_q == S_MISS_REQ) begin
          // done may ride along with ack; skip the wait state in that case.
          if (refill_ack) state_d = refill_done ? S_RETRY : S_MISS_WAIT;
        end else if (refill_done) begin
          state_d = S_RETRY;
        end
      end

      S_RETRY: begin
        if (redirect) begin
          pc_en             = 1'b1;
          next_inst_address = redir_tgt;
        end else if (pend_vld_q) begin
          pc_en             = 1'b1;
          next_inst_address = pend_tgt_q;
        end
        pend_vld_d = 1'b0;
        state_d    = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    // Reset loads RESET_PC into pc_reg on the same edge that clears state.
    if (rst) begin
      pc_en             = 1'b1;
      next_inst_address = RESET_PC;
      fetch_valid       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pend_vld_q    <= 1'b0;
      pend_tgt_q    <= 32'd0;
      refill_addr_q <= 32'd0;
      miss_count_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      pend_vld_q    <= pend_vld_d;
      pend_tgt_q    <= pend_tgt_d;
      refill_addr_q <= refill_addr_d;
      miss_count_q  <= miss_count_d;
    end
  end

  assign refill_req  = (state_q == S_MISS_REQ);
  assign refill_addr = refill_addr_q;
  assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam logic [31:0] RPC  = 32'h0040_0000;
  localparam int unsigned LINE = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, icache_hit = 1'b0, stall = 1'b0;
  logic        jump = 1'b0, branch_taken = 1'b0, refill_ack = 1'b0, refill_done = 1'b0;
  logic [31:0] inst_address = 32'd0, jump_target = 32'd0, branch_target = 32'd0;
  logic [31:0] next_inst_address, refill_addr, miss_count;
  logic        pc_en, fetch_valid, refill_req;

  fetch_ctrl #(.RESET_PC(RPC), .LINE_BYTES(LINE)) dut (
    .clk(clk), .rst(rst), .inst_address(inst_address), .icache_hit(icache_hit),
    .stall(stall), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .refill_ack(refill_ack), .refill_done(refill_done),
    .next_inst_address(next_inst_address), .pc_en(pc_en), .fetch_valid(fetch_valid),
    .refill_req(refill_req), .refill_addr(refill_addr), .miss_count(miss_count)
  );

  typedef struct {
    bit rst, hit, stall, j; logic [31:0] jt; bit b; logic [31:0] bt; bit ack, done;
  } stim_t;

  typedef struct {
    bit chk_req, chk_next, pc_en, fv, req;
    logic [31:0] nxt, raddr, cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0, n_bad = 0;

  // Reference model: a miss is a "refill in progress" with an outstanding-request
  // flag; parked redirects form a list where only the newest matters.
  logic [31:0] m_pc = 32'd0, m_raddr = 32'd0, m_cnt = 32'd0;
  bit m_busy = 0, m_req = 0, m_retry = 0;
  logic [31:0] m_pend[$];

  function automatic stim_t S(bit r, bit h, bit st, bit j, logic [31:0] jt,
                              bit b, logic [31:0] bt, bit a, bit d);
    stim_t s;
    s.rst = r; s.hit = h; s.stall = st; s.j = j; s.jt = jt;
    s.b = b; s.bt = bt; s.ack = a; s.done = d;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit redir;
    logic [31:0] tgt;
    @(posedge clk); #1;
    rst = s.rst; icache_hit = s.hit; stall = s.stall; jump = s.j; jump_target = s.jt;
    branch_taken = s.b; branch_target = s.bt; refill_ack = s.ack; refill_done = s.done;
    inst_address = m_pc;
    redir = s.j | s.b;
    tgt   = s.j ? s.jt : s.bt;
    e.chk_req = !s.rst; e.req = m_busy && m_req;
    e.raddr = m_raddr; e.cnt = m_cnt;
    e.pc_en = 0; e.fv = 0; e.chk_next = 0; e.nxt = 32'd0;
    if (s.rst) begin
      e.pc_en = 1; e.chk_next = 1; e.nxt = RPC;
      m_busy = 0; m_req = 0; m_retry = 0; m_pend.delete();
      m_raddr = 32'd0; m_cnt = 32'd0;
    end else if (m_retry) begin
      if (redir) begin e.pc_en = 1; e.nxt = tgt; end
      else if (m_pend.size() != 0) begin e.pc_en = 1; e.nxt = m_pend[$]; end
      e.chk_next = e.pc_en;
      m_retry = 0; m_pend.delete();
    end else if (m_busy) begin
      if (redir) m_pend.push_back(tgt);
      if (s.done && (!m_req || s.ack)) begin m_busy = 0; m_retry = 1; end
      if (m_req && s.ack) m_req = 0;
    end else begin
      if (redir) begin e.pc_en = 1; e.nxt = tgt; end
      else if (s.stall) e.pc_en = 0;
      else if (s.hit) begin e.pc_en = 1; e.nxt = m_pc + 32'd4; e.fv = 1; end
      else begin
        m_raddr = m_pc - (m_pc % LINE);
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_busy = 1; m_req = 1;
      end
      e.chk_next = e.pc_en;
    end
    if (e.pc_en) m_pc = e.nxt;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc_en", 32'(pc_en), 32'(e.pc_en));
        chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
        if (e.chk_next) chk("next_inst_address", next_inst_address, e.nxt);
        if (e.chk_req) chk("refill_req", 32'(refill_req), 32'(e.req));
        chk("refill_addr", refill_addr, e.raddr);
        chk("miss_count", miss_count, e.cnt);
      end
    end
  end

  initial begin
    // Reset, then straight-line hits from RESET_PC.
    step(S(1,0,0,0,0,0,0,0,0));
    step(S(1,0,0,0,0,0,0,0,0));
    repeat (3) step(S(0,1,0,0,0,0,0,0,0));
    // Miss at 0x1C: ack after 3 request cycles, done 2 cycles later.
    step(S(0,1,0,1,32'h1C,0,0,0,0));
    step(S(0,0,0,0,0,0,0,0,0));
    step(S(0,0,0,0,0,0,0,0,0));
    step(S(0,0,1,0,0,0,0,0,0));
    step(S(0,0,0,0,0,0,0,1,0));
    step(S(0,0,0,0,0,0,0,0,0));
    step(S(0,0,0,0,0,0,0,0,1));
    step(S(0,0,0,0,0,0,0,0,0));
    step(S(0,1,0,0,0,0,0,0,0));
    // Redirects parked during a miss; newest wins in RETRY.
    step(S(0,1,0,1,32'h40,0,0,0,0));
    step(S(0,0,0,0,0,0,0,0,0));
    step(S(0,0,0,0,0,0,0,1,0));
    step(S(0,0,0,0,0,1,32'h100,0,0));
    step(S(0,0,0,1,32'h200,0,0,0,1));
    step(S(0,0,0,0,0,0,0,0,0));
    step(S(0,1,0,0,0,0,0,0,0));
    // Ack and done together; redirect in RETRY overrides parked one.
    step(S(0,0,0,0,0,0,0,0,0));
    step(S(0,0,0,0,0,1,32'h300,1,1));
    step(S(0,0,0,0,0,1,32'h340,0,0));
    step(S(0,1,0,0,0,0,0,0,0));
    // Priority: jump beats branch beats stall; then stall alone.
    step(S(0,1,1,1,32'h80,1,32'h40,0,0));
    step(S(0,1,1,0,0,0,0,0,0));
    step(S(0,1,1,0,0,0,0,0,0));
    // Wrap.
    step(S(0,1,0,1,32'hFFFF_FFFC,0,0,0,0));
    step(S(0,1,0,0,0,0,0,0,0));
    step(S(0,1,0,0,0,0,0,0,0));
    // Reset mid-miss, then stray done.
    step(S(0,0,0,0,0,0,0,0,0));
    step(S(0,0,0,0,0,1,32'h500,0,0));
    step(S(1,0,0,0,0,0,0,0,0));
    step(S(0,0,0,0,0,0,0,0,1));
    step(S(0,1,0,0,0,0,0,1,1));
    step(S(0,1,0,0,0,0,0,0,0));
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      stim_t s;
      s.rst   = ($urandom_range(0, 99) == 0);
      s.hit   = ($urandom_range(0, 3) != 0);
      s.stall = ($urandom_range(0, 4) == 0);
      s.j     = ($urandom_range(0, 11) == 0);
      s.b     = ($urandom_range(0, 9) == 0);
      s.jt    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hC)
                                            : $urandom & 32'hFFFF_FFFC;
      s.bt    = $urandom & 32'hFFFF_FFFC;
      s.ack   = ($urandom_range(0, 2) == 0);
      s.done  = ($urandom_range(0, 2) == 0);
      step(s);
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
